sync_arbiter: RTL and testbench

- Shares one signal_sync channel (pulse CDC plus quasi-static data bus) among N_REQ requesters in the source clock domain.
- Captures per-requester command pulses and payloads, and grants round-robin.
- Issues a one-cycle start to signal_sync and holds the payload bus stable for a programmed hold window, so the destination domain samples it safely on its ready pulse.
- Acks each requester on completion.

---
 rtl/sync_arbiter.sv | 133 +++++++++++++
 tb/tb_sync_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_arbiter.sv
// Round-robin arbiter sharing one signal_sync channel among N_REQ requesters.
// Captures command pulses/payloads, issues start, holds data, acks on finish.
module sync_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 8,
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW  = $clog2(HOLD_CYCLES + 1)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic                    ovr_clr,
   output logic [N_REQ-1:0]        pend,
   output logic [N_REQ-1:0]        done,
   output logic [N_REQ-1:0]        overrun,
   output logic                    busy,
   output logic [IDW-1:0]          grant_id,
   output logic                    sync_start,
   output logic [DATA_W-1:0]       sync_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t                  state, state_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic [IDW-1:0]          rr, rr_n;
   logic [IDW-1:0]          sel, gid_n;
   logic [IDW:0]            idx;
   logic                    found;
   logic [N_REQ-1:0]        clr, pend_n, ovr_n, done_n;
   logic [N_REQ*DATA_W-1:0] data_q, data_n;
   logic [DATA_W-1:0]       sdata_n;
   logic                    busy_n, start_n;

   // first pending bit at or above rr, wrapping
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, rr} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(N_REQ))
            idx = idx - (IDW+1)'(N_REQ);
         if (!found && pend[idx[IDW-1:0]]) begin
            found = 1'b1;
            sel   = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rr_n    = rr;
      gid_n   = grant_id;
      sdata_n = sync_data;
      busy_n  = busy;
      start_n = 1'b0;
      done_n  = '0;
      clr     = '0;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_n  = ISSUE;
               gid_n    = sel;
               sdata_n  = data_q[sel*DATA_W +: DATA_W];
               clr[sel] = 1'b1;
               busy_n   = 1'b1;
               start_n  = 1'b1;
               if (sel == IDW'(N_REQ-1))
                  rr_n = '0;
               else
                  rr_n = sel + 1'b1;
            end
         end
         ISSUE: begin
            state_n = HOLD;
            cnt_n   = CW'(HOLD_CYCLES-1);
         end
         HOLD: begin
            if (cnt == '0) begin
               state_n          = IDLE;
               done_n[grant_id] = 1'b1;
               busy_n           = 1'b0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // a grant clearing pend in the same cycle masks the overrun
   always_comb begin
      pend_n = (pend & ~clr) | req;
      ovr_n  = (ovr_clr ? '0 : overrun) | (req & pend & ~clr);
      data_n = data_q;
      for (int i = 0; i < N_REQ; i++)
         if (req[i])
            data_n[i*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         rr         <= '0;
         grant_id   <= '0;
         sync_data  <= '0;
         busy       <= 1'b0;
         sync_start <= 1'b0;
         done       <= '0;
         pend       <= '0;
         overrun    <= '0;
         data_q     <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         rr         <= rr_n;
         grant_id   <= gid_n;
         sync_data  <= sdata_n;
         busy       <= busy_n;
         sync_start <= start_n;
         done       <= done_n;
         pend       <= pend_n;
         overrun    <= ovr_n;
         data_q     <= data_n;
      end
   end

endmodule

// File: tb/tb_sync_arbiter.sv
// Directed bench for sync_arbiter (N_REQ=4, DATA_W=8, HOLD_CYCLES=8).
// Expected values are hand-derived cycle offsets from each request.
module tb_sync_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic        ovr_clr = 1'b0;
   logic [3:0]  pend, done, overrun;
   logic        busy, sync_start;
   logic [1:0]  grant_id;
   logic [7:0]  sync_data;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int c0;

   sync_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYCLES(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_data   (req_data),
      .ovr_clr    (ovr_clr),
      .pend       (pend),
      .done       (done),
      .overrun    (overrun),
      .busy       (busy),
      .grant_id   (grant_id),
      .sync_start (sync_start),
      .sync_data  (sync_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      req_data[i*8 +: 8] = v;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      req      = '0;
      req_data = '0;
      ovr_clr  = 1'b0;
      #3;
      chk("rst_pend", pend, 0);
      chk("rst_done", done, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", sync_start, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_sdata", sync_data, 0);
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      // 1: single request
      do_reset();
      tick();
      c0 = cyc;
      req = 4'b0100;
      set_data(2, 8'hA5);
      tick();
      req = '0;
      chk("t1_pend", pend, 4'b0100);
      chk("t1_nostart", sync_start, 0);
      tick();
      chk("t1_start", sync_start, 1);
      chk("t1_gid", grant_id, 2);
      chk("t1_sdata", sync_data, 8'hA5);
      chk("t1_busy", busy, 1);
      chk("t1_pendclr", pend, 0);
      tick();
      chk("t1_start1", sync_start, 0);
      run_to(c0 + 10);
      chk("t1_nodone", done, 0);
      chk("t1_busy10", busy, 1);
      tick();
      chk("t1_done", done, 4'b0100);
      chk("t1_busy0", busy, 0);
      tick();
      chk("t1_done1", done, 0);
      chk("t1_hold", sync_data, 8'hA5);

      // 2: all four at once
      do_reset();
      c0 = cyc;
      req = 4'b1111;
      req_data = 32'h13121110;
      tick();
      req = '0;
      chk("t2_pend", pend, 4'b1111);
      tick();
      chk("t2_pend2", pend, 4'b1110);
      for (int i = 0; i < 4; i++) begin
         run_to(c0 + 2 + 10*i);
         chk("t2_start", sync_start, 1);
         chk("t2_gid", grant_id, i);
         chk("t2_sdata", sync_data, 8'h10 + i);
         run_to(c0 + 11 + 10*i);
         chk("t2_done", done, 1 << i);
         chk("t2_busy", busy, 0);
      end

      // 3: fairness with requester 0 hammering
      do_reset();
      c0 = cyc;
      req_data = 32'h3C000001;
      for (int n = 0; n <= 32; n++) begin
         if (n == 2 || n == 22 || n == 32) begin
            chk("t3_start", sync_start, 1);
            chk("t3_gid0", grant_id, 0);
         end
         if (n == 12) begin
            chk("t3_start3", sync_start, 1);
            chk("t3_gid3", grant_id, 3);
            chk("t3_sdata3", sync_data, 8'h3C);
         end
         req = (n == 1) ? 4'b1001 : 4'b0001;
         tick();
      end
      req = '0;
      chk("t3_ovr", overrun, 4'b0001);

      // 4: overrun on requester 1 while 0 is held
      do_reset();
      c0 = cyc;
      req = 4'b0001;
      set_data(0, 8'h01);
      tick();
      req = '0;
      run_to(c0 + 4);
      req = 4'b0010;
      set_data(1, 8'h55);
      tick();
      req = '0;
      run_to(c0 + 6);
      chk("t4_pend", pend, 4'b0010);
      chk("t4_ovr0", overrun, 0);
      req = 4'b0010;
      set_data(1, 8'h66);
      tick();
      req = '0;
      chk("t4_ovr", overrun, 4'b0010);
      run_to(c0 + 11);
      chk("t4_done0", done, 4'b0001);
      tick();
      chk("t4_start", sync_start, 1);
      chk("t4_gid", grant_id, 1);
      chk("t4_sdata", sync_data, 8'h66);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      tick();
      chk("t4_ovrclr", overrun, 0);

      // 5: re-request in the grant cycle
      do_reset();
      c0 = cyc;
      req = 4'b0010;
      set_data(1, 8'h66);
      tick();
      set_data(1, 8'h77);
      tick();
      req = '0;
      chk("t5_start", sync_start, 1);
      chk("t5_sdata", sync_data, 8'h66);
      chk("t5_pend", pend, 4'b0010);
      chk("t5_ovr", overrun, 0);
      run_to(c0 + 12);
      chk("t5_start2", sync_start, 1);
      chk("t5_gid2", grant_id, 1);
      chk("t5_sdata2", sync_data, 8'h77);
      chk("t5_ovr2", overrun, 0);

      // 6: asynchronous reset in the middle of HOLD
      do_reset();
      c0 = cyc;
      req = 4'b0001;
      set_data(0, 8'h42);
      tick();
      req = '0;
      run_to(c0 + 6);
      chk("t6_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_busy0", busy, 0);
      chk("t6_start0", sync_start, 0);
      chk("t6_pend0", pend, 0);
      chk("t6_done0", done, 0);
      chk("t6_sdata0", sync_data, 0);
      tick();
      reset_n = 1'b1;
      for (int n = 0; n < 15; n++) begin
         tick();
         chk("t6_nodone", done, 0);
      end
      c0 = cyc;
      req = 4'b1001;
      req_data = 32'hD00000E0;
      tick();
      req = '0;
      tick();
      chk("t6_start", sync_start, 1);
      chk("t6_gid", grant_id, 0);
      chk("t6_sdata", sync_data, 8'hE0);
      chk("t6_pend", pend, 4'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
